rx_echo_capture: RTL and testbench

Receive-side counterpart of the 64-element Transmitter. After each transmit event it measures, for every transducer element, the time of flight in clk cycles (25 MHz sample clock) from transmit start to the first rising edge on that element's echo-detect line. After the listen window closes, it streams the 64 measurements out through a valid/ready port for delay verification and aperture calibration.

---
 rtl/rx_echo_capture.sv | 170 +++++++++++++++++
 tb/tb_rx_echo_capture.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_echo_capture.sv
// rx_echo_capture: per-element time-of-flight capture with streamed readout.
// Optional echo blanking after transmit is enabled by defining RX_BLANKING_EN.
module rx_echo_capture #(
    parameter int NUM_CH       = 64,
    parameter int DW_TIME      = 16,
    parameter int CH_W         = 6,
    parameter int BLANK_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DW_TIME-1:0] window_len,
    input  logic [NUM_CH-1:0]  rxArray,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [CH_W-1:0]    rd_channel,
    output logic [DW_TIME-1:0] rd_tof,
    output logic               rd_hit,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LISTEN,
        S_READOUT,
        S_DONE
    } state_t;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    // Channel index must address every element exactly.
    if (CH_W != $clog2(NUM_CH) || BLANK_CYCLES < 0) begin : g_param_check
        $error("rx_echo_capture: bad CH_W or BLANK_CYCLES");
    end

    state_t state_q;
    state_t state_d;

    logic [DW_TIME-1:0] win_q;
    logic [DW_TIME-1:0] cnt_q;
    logic [NUM_CH-1:0]  prev_q;
    logic [NUM_CH-1:0]  hit_q;
    logic [DW_TIME-1:0] tof_q [NUM_CH];
    logic [CH_W-1:0]    ch_q;

    logic [NUM_CH-1:0]  rise;
    logic [NUM_CH-1:0]  new_hit;
    logic [NUM_CH-1:0]  hit_nxt;
    logic [CH_W-1:0]    ch_sel;
    logic               listen_end;
    logic               last_accept;
    logic               accept_start;

    // Edge detection, first-hit selection and exit/handshake conditions.
    always_comb begin
        rise = rxArray & ~prev_q;
`ifdef RX_BLANKING_EN
        if (cnt_q < DW_TIME'(BLANK_CYCLES)) begin
            rise = '0;
        end
`endif
        new_hit      = rise & ~hit_q;
        hit_nxt      = hit_q | new_hit;
        listen_end   = (cnt_q == win_q - DW_TIME'(1)) || (&hit_nxt);
        last_accept  = rd_valid && rd_ready && (ch_q == LAST_CH);
        ch_sel       = rd_valid ? ch_q + CH_W'(1) : ch_q;
        accept_start = (state_q == S_IDLE) && start;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LISTEN;
                end
            end
            S_LISTEN: begin
                busy = 1'b1;
                if (listen_end) begin
                    state_d = S_READOUT;
                end
            end
            S_READOUT: begin
                busy = 1'b1;
                if (last_accept) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Capture: arm on start, then record the cycle of each first rising edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_q  <= '0;
            cnt_q  <= '0;
            prev_q <= '1;
            hit_q  <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                tof_q[n] <= '0;
            end
        end else if (accept_start) begin
            // A zero window still listens for one cycle.
            win_q  <= (window_len == '0) ? DW_TIME'(1) : window_len;
            cnt_q  <= '0;
            // Lines already high when armed must not count as edges.
            prev_q <= '1;
            hit_q  <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                tof_q[n] <= '0;
            end
        end else if (state_q == S_LISTEN) begin
            prev_q <= rxArray;
            hit_q  <= hit_nxt;
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + DW_TIME'(1);
            end
            for (int n = 0; n < NUM_CH; n++) begin
                if (new_hit[n]) begin
                    tof_q[n] <= cnt_q;
                end
            end
        end
    end

    // Readout: registered word, held under backpressure, one per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid   <= 1'b0;
            rd_channel <= '0;
            rd_tof     <= '0;
            rd_hit     <= 1'b0;
            ch_q       <= '0;
        end else if (accept_start) begin
            ch_q <= '0;
        end else if (state_q == S_READOUT) begin
            if (!rd_valid || (rd_ready && ch_q != LAST_CH)) begin
                rd_valid   <= 1'b1;
                ch_q       <= ch_sel;
                rd_channel <= ch_sel;
                rd_tof     <= tof_q[ch_sel];
                rd_hit     <= hit_q[ch_sel];
            end else if (last_accept) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_echo_capture.sv
// tb_rx_echo_capture: directed bench for rx_echo_capture.
// Expected values are hand-derived from the echo timing driven below.
module tb_rx_echo_capture;

    localparam int NUM_CH  = 64;
    localparam int DW_TIME = 16;
    localparam int CH_W    = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [DW_TIME-1:0] window_len = '0;
    logic [NUM_CH-1:0]  rx_array = '0;
    logic               rd_ready = 1'b0;
    logic               rd_valid;
    logic [CH_W-1:0]    rd_channel;
    logic [DW_TIME-1:0] rd_tof;
    logic               rd_hit;
    logic               busy;
    logic               done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW_TIME-1:0] exp_tof [NUM_CH];
    logic               exp_hit [NUM_CH];

    always #5 clk = ~clk;

    rx_echo_capture #(
        .NUM_CH      (NUM_CH),
        .DW_TIME     (DW_TIME),
        .CH_W        (CH_W),
        .BLANK_CYCLES(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .window_len(window_len),
        .rxArray   (rx_array),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_channel(rd_channel),
        .rd_tof    (rd_tof),
        .rd_hit    (rd_hit),
        .busy      (busy),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < NUM_CH; i++) begin
            exp_tof[i] = '0;
            exp_hit[i] = 1'b0;
        end
    endtask

    task automatic do_start(input logic [DW_TIME-1:0] wl);
        start      = 1'b1;
        window_len = wl;
        tick();
        start = 1'b0;
    endtask

    // mode 0: ready always; mode 1: alternating, 5-cycle stall at ch 20
    task automatic read_all(input int mode);
        int got   = 0;
        int cyc   = 0;
        int stall = 0;
        while (got < NUM_CH && cyc < 600) begin
            if (mode == 0) begin
                rd_ready = 1'b1;
            end else if (rd_valid && got == 20 && stall < 5) begin
                rd_ready = 1'b0;
                stall++;
            end else begin
                rd_ready = cyc[0];
            end
            if (rd_valid) begin
                check("rd_channel", 32'(rd_channel), got);
                check("rd_tof", 32'(rd_tof), 32'(exp_tof[got]));
                check("rd_hit", 32'(rd_hit), 32'(exp_hit[got]));
                if (rd_ready) begin
                    got++;
                end
            end
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        check("handshakes", got, NUM_CH);
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        check("done_valid", 32'(rd_valid), 0);
        tick();
        check("done_clear", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;

        // Reset and idle behaviour
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_channel", 32'(rd_channel), 0);
        check("rst_tof", 32'(rd_tof), 0);
        check("rst_hit", 32'(rd_hit), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        for (int k = 0; k < 6; k++) begin
            rx_array = ~rx_array;
            tick();
            check("idle_rx_busy", 32'(busy), 0);
            check("idle_rx_valid", 32'(rd_valid), 0);
        end
        rx_array = '0;
        tick();

        // Basic capture, window 100
        clear_exp();
        exp_tof[0]  = 16'd10; exp_hit[0]  = 1'b1;
        exp_tof[31] = 16'd42; exp_hit[31] = 1'b1;
        exp_tof[63] = 16'd99; exp_hit[63] = 1'b1;
        do_start(16'd100);
        for (int k = 0; k < 100; k++) begin
            rx_array     = '0;
            rx_array[0]  = (k == 10);
            rx_array[31] = (k == 42);
            rx_array[63] = (k == 99);
            tick();
            if (k == 50) begin
                check("listen_busy", 32'(busy), 1);
            end
        end
        rx_array = '0;
        check("basic_gap_valid", 32'(rd_valid), 0);
        check("basic_gap_busy", 32'(busy), 1);
        tick();
        check("basic_first_valid", 32'(rd_valid), 1);
        read_all(0);

        // Early exit on all hits, duplicates ignored
        clear_exp();
        for (int i = 0; i < NUM_CH; i++) begin
            exp_tof[i] = 16'd5;
            exp_hit[i] = 1'b1;
        end
        do_start(16'd1000);
        for (int k = 0; k <= 5; k++) begin
            rx_array = (k == 5) ? '1 : '0;
            tick();
        end
        check("early_gap_valid", 32'(rd_valid), 0);
        check("early_gap_busy", 32'(busy), 1);
        rx_array = '0;
        tick();
        check("early_valid", 32'(rd_valid), 1);
        rx_array = '1;
        read_all(0);
        rx_array = '0;

        // Zero window with a line held high at start
        clear_exp();
        rx_array[9] = 1'b1;
        do_start(16'd0);
        tick();
        check("w0_gap_valid", 32'(rd_valid), 0);
        check("w0_busy", 32'(busy), 1);
        tick();
        check("w0_valid", 32'(rd_valid), 1);
        rx_array = '0;
        read_all(0);

        // Backpressure
        clear_exp();
        exp_tof[20] = 16'd3; exp_hit[20] = 1'b1;
        exp_tof[21] = 16'd6; exp_hit[21] = 1'b1;
        do_start(16'd8);
        for (int k = 0; k < 8; k++) begin
            rx_array     = '0;
            rx_array[20] = (k >= 3);
            rx_array[21] = (k == 6);
            tick();
        end
        rx_array = '0;
        read_all(1);

        // Second start ignored in LISTEN, then reset abort at ch 10
        clear_exp();
        exp_tof[5] = 16'd4; exp_hit[5] = 1'b1;
        do_start(16'd50);
        for (int k = 0; k < 50; k++) begin
            rx_array    = '0;
            rx_array[5] = (k >= 4);
            start       = (k == 2);
            tick();
            if (k == 2) begin
                check("restart_busy", 32'(busy), 1);
            end
        end
        start    = 1'b0;
        rx_array = '0;
        rd_ready = 1'b1;
        cyc      = 0;
        while (!(rd_valid && rd_channel == 6'd10) && cyc < 100) begin
            if (rd_valid) begin
                check("abort_tof", 32'(rd_tof), 32'(exp_tof[rd_channel]));
                check("abort_hit", 32'(rd_hit), 32'(exp_hit[rd_channel]));
            end
            tick();
            cyc++;
        end
        check("abort_reach_ch10", 32'(rd_channel), 10);
        rst      = 1'b0;
        rd_ready = 1'b0;
        tick();
        check("abort_valid", 32'(rd_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_channel", 32'(rd_channel), 0);
        rst = 1'b1;
        tick();
        check("abort_no_done", 32'(done), 0);
        check("abort_idle_valid", 32'(rd_valid), 0);
        tick();
        check("abort_no_done2", 32'(done), 0);

        // Fresh start with no echoes
        clear_exp();
        do_start(16'd3);
        for (int k = 0; k < 3; k++) begin
            tick();
        end
        read_all(0);

        // Blanking window behaviour
        clear_exp();
`ifdef RX_BLANKING_EN
        exp_tof[3] = 16'd0; exp_hit[3] = 1'b0;
`else
        exp_tof[3] = 16'd4; exp_hit[3] = 1'b1;
`endif
        exp_tof[4] = 16'd8; exp_hit[4] = 1'b1;
        do_start(16'd20);
        for (int k = 0; k < 20; k++) begin
            rx_array    = '0;
            rx_array[3] = (k >= 4);
            rx_array[4] = (k >= 8);
            tick();
        end
        rx_array = '0;
        read_all(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
